sseg_scan_mux: RTL

- Time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display.
- Takes a packed N-digit hex word with per-digit decimal-point and blank masks.
- Decodes each digit to segments internally, using the team's standard hex-to-segment map.
- Scans one digit at a time at a prescaled refresh rate. Sits between datapath registers and the board's display pins.

---
 rtl/sseg_scan_mux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver: snapshots an N-digit hex word once per frame
// and scans one digit per prescaled slot, with registered, glitch-free an/sseg outputs.
module sseg_scan_mux #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned DIV            = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          LZ_BLANK       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] hex,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_POL = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0] SEG_POL = {8{SEG_ACTIVE_LOW}};

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  first_q, first_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  frame_q, frame_d;

    logic                  tick;
    logic                  snap;

    // The first tick after reset restarts the frame at digit 0 so a fresh snapshot is shown in order.
    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        snap    = tick && (first_q || (idx_q == IDX_MAX));
        first_d = first_q & ~tick;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = snap ? '0 : idx_q + 1'b1;
        end
        hex_d   = snap ? hex   : hex_q;
        dp_d    = snap ? dp    : dp_q;
        blank_d = snap ? blank : blank_q;
        frame_d = snap;
    end

    logic [3:0]          digit;
    logic                dp_bit;
    logic                blank_bit;
    logic [N_DIGITS-1:0] onehot;
    logic [N_DIGITS-1:0] lz_vec;
    logic                zero_run;
    logic                lz_cur;
    logic [6:0]          seg7;

    always_comb begin
        digit     = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        onehot    = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                digit     = hex_q[4*i +: 4];
                dp_bit    = dp_q[i];
                blank_bit = blank_q[i];
                onehot[i] = 1'b1;
            end
        end

        // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            zero_run  = zero_run & (hex_q[4*i +: 4] == 4'h0);
            lz_vec[i] = zero_run;
        end
        lz_cur = LZ_BLANK && (|(lz_vec & onehot));

        case (digit)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase

        if (blank_bit || !en) begin
            an_d   = AN_POL;
            sseg_d = SEG_POL;
        end else begin
            an_d   = onehot ^ AN_POL;
            sseg_d = {dp_bit, (lz_cur ? 7'h00 : seg7)} ^ SEG_POL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            an_q    <= AN_POL;
            sseg_q  <= SEG_POL;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign sseg  = sseg_q;
    assign frame = frame_q;

endmodule
